// File: rtl/mv_node_if.sv
// mv_node_if: operand stream in, forwarded vector and dot-product result out.
interface mv_node_if #(parameter int AW = 25, BW = 18, OW = 25, LW = 10);
    logic                 in_valid;
    logic signed [AW-1:0] ain;
    logic signed [BW-1:0] bin;
    logic                 sub;
    logic [LW-1:0]        len;
    logic signed [AW-1:0] aout;
    logic                 aout_valid;
    logic signed [OW-1:0] res;
    logic                 res_valid;
    logic                 ovf;
    logic                 busy;
    modport master (output in_valid, ain, bin, sub, len,
                    input  aout, aout_valid, res, res_valid, ovf, busy);
    modport slave  (input  in_valid, ain, bin, sub, len,
                    output aout, aout_valid, res, res_valid, ovf, busy);
endinterface

// File: rtl/mv_node.sv
// mv_node: pipelined signed MAC node producing one rounded, saturated dot product per vector.
module mv_node #(
    parameter int AW   = 25,
    parameter int BW   = 18,
    parameter int ACCW = 48,
    parameter int FRAC = 17,
    parameter int OW   = 25,
    parameter int LW   = 10
) (
    input logic        clk,
    input logic        rstn,
    input logic        sclr,
    mv_node_if.slave   io
);
    localparam logic signed [ACCW:0] max_v = {{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW:0] min_v = ~max_v;
    localparam logic signed [ACCW:0] rnd   = {{ACCW{1'b0}}, 1'b1} << FRAC >> 1;
    logic [LW-1:0]          cnt, l_q, len_eff;
    logic                   first_in, last_in;
    logic                   v1, f1, l1, s1, v2, f2, l2, s2;
    logic signed [AW-1:0]   a1;
    logic signed [BW-1:0]   b1;
    logic [ACCW-1:0]        p2, acc, base, acc_next;
    logic signed [ACCW:0]   rsum, r;
    logic                   hi, lo;
    assign io.busy = cnt != '0;
    always_comb begin
        len_eff  = io.len == '0 ? LW'(1) : io.len;
        first_in = cnt == '0;
        last_in  = first_in ? len_eff == LW'(1) : cnt == l_q - LW'(1);
        base     = f2 ? '0 : acc;
        acc_next = s2 ? base - p2 : base + p2;
        // one guard bit so the rounding increment cannot wrap the accumulator
        rsum     = $signed({acc_next[ACCW-1], acc_next}) + rnd;
        r        = rsum >>> FRAC;
        hi       = r > max_v;
        lo       = r < min_v;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            io.aout       <= '0;
            io.aout_valid <= 1'b0;
        end else begin
            io.aout       <= io.ain;
            io.aout_valid <= io.in_valid;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {cnt, l_q, v1, f1, l1, s1, a1, b1, v2, f2, l2, s2, p2, acc} <= '0;
            io.res       <= '0;
            io.ovf       <= 1'b0;
            io.res_valid <= 1'b0;
        end else if (sclr) begin
            {cnt, l_q, v1, v2, acc} <= '0;
            io.res       <= '0;
            io.ovf       <= 1'b0;
            io.res_valid <= 1'b0;
        end else begin
            v1           <= io.in_valid;
            v2           <= v1;
            io.res_valid <= v2 && l2;
            if (io.in_valid) begin
                a1  <= io.ain;
                b1  <= io.bin;
                s1  <= io.sub;
                f1  <= first_in;
                l1  <= last_in;
                cnt <= last_in ? '0 : cnt + LW'(1);
                if (first_in) l_q <= len_eff;
            end
            if (v1) begin
                p2 <= {{(ACCW-AW){a1[AW-1]}}, a1} * {{(ACCW-BW){b1[BW-1]}}, b1};
                f2 <= f1;
                l2 <= l1;
                s2 <= s1;
            end
            if (v2) begin
                acc <= acc_next;
                if (l2) begin
                    io.res <= hi ? max_v[OW-1:0] : lo ? min_v[OW-1:0] : r[OW-1:0];
                    io.ovf <= hi || lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_mv_node.sv
// tb_mv_node: directed and random stimulus for mv_node against a real-arithmetic dot-product model.
module tb_mv_node;
    logic clk = 1'b0, rstn = 1'b0, sclr = 1'b0;
    always #5 clk = ~clk;
    mv_node_if bus();
    mv_node dut (.clk(clk), .rstn(rstn), .sclr(sclr), .io(bus));
    typedef struct {int due; longint val; logic o;} res_t;
    res_t   pend[$];
    int     n_chk = 0, n_fail = 0, cyc = 0, cnt_m = 0, len_m = 1;
    longint sum_m = 0, exp_res = 0;
    logic   exp_ovf = 1'b0;
    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_res"}, bus.res, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_aout"}, bus.aout, 0);
        chk({tag, "_aout_valid"}, bus.aout_valid, 0);
    endtask
    task automatic step(input logic v, input longint a, input longint b,
                        input logic s, input int l, input logic sc);
        real    q;
        longint rr;
        res_t   e;
        logic   rv;
        bus.in_valid = v;
        bus.ain      = a[24:0];
        bus.bin      = b[17:0];
        bus.sub      = s;
        bus.len      = l[9:0];
        sclr         = sc;
        cyc++;
        if (sc) begin
            cnt_m = 0;
            pend.delete();
        end else if (v) begin
            if (cnt_m == 0) begin
                len_m = (l == 0) ? 1 : l;
                sum_m = 0;
            end
            sum_m += s ? -(a * b) : a * b;
            cnt_m++;
            if (cnt_m == len_m) begin
                q  = $floor(real'(sum_m) / 131072.0 + 0.5);
                rr = longint'(q);
                e.due = cyc + 2;
                e.o   = (rr > 16777215) || (rr < -16777216);
                e.val = rr > 16777215 ? 16777215 : rr < -16777216 ? -16777216 : rr;
                pend.push_back(e);
                cnt_m = 0;
            end
        end
        @(posedge clk);
        #1;
        sclr = 1'b0;
        if (sc) begin
            exp_res = 0;
            exp_ovf = 1'b0;
        end
        rv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_res = pend[0].val;
            exp_ovf = pend[0].o;
            void'(pend.pop_front());
            rv = 1'b1;
        end
        chk("res_valid", bus.res_valid, rv);
        chk("res", bus.res, exp_res);
        chk("ovf", bus.ovf, exp_ovf);
        chk("busy", bus.busy, cnt_m != 0);
        chk("aout", bus.aout, a);
        chk("aout_valid", bus.aout_valid, v);
    endtask
    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        bus.in_valid = 0; bus.ain = 0; bus.bin = 0; bus.sub = 0; bus.len = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk) rstn = 1'b1;
        // basic dot product: 1.0 * (2+3+4+5)
        for (int i = 2; i <= 5; i++) step(1, 131072, i, 0, 4, 0);
        idle(2);
        chk("basic_const", bus.res, 14);
        chk("basic_ovf", bus.ovf, 0);
        for (int i = 2; i <= 5; i++) step(1, 131072, i, i == 3, 4, 0);
        idle(2);
        chk("sub_const", bus.res, 8);
        step(1, 1, 65536, 0, 1, 0);
        idle(2);
        chk("round_up_const", bus.res, 1);
        step(1, -1, 65536, 0, 1, 0);
        idle(2);
        chk("round_neg_const", bus.res, 0);
        repeat (4) step(1, 16777215, 131071, 0, 4, 0);
        idle(2);
        chk("sat_hi_const", bus.res, 16777215);
        chk("sat_hi_ovf", bus.ovf, 1);
        repeat (4) step(1, -16777216, 131071, 0, 4, 0);
        idle(2);
        chk("sat_lo_const", bus.res, -16777216);
        chk("sat_lo_ovf", bus.ovf, 1);
        // back-to-back len=2 vectors; len=3 on the second term of each must be ignored
        for (int i = 0; i < 6; i++)
            step(1, 131072 * (i + 1), 3 - i, 0, (i % 2) ? 3 : 2, 0);
        idle(3);
        repeat (2) step(1, 131072, 9, 0, 4, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("sclr_busy", bus.busy, 0);
        idle(3);
        step(1, 131072, 7, 0, 1, 0);
        idle(2);
        chk("after_sclr_const", bus.res, 7);
        repeat (2) step(1, 131072, 5, 0, 4, 0);
        #2 rstn = 1'b0;
        #1 chk_zero("async_reset");
        cnt_m = 0; pend.delete(); exp_res = 0; exp_ovf = 1'b0;
        bus.in_valid = 0;
        #2 rstn = 1'b1;
        idle(2);
        repeat (400) begin
            step($urandom_range(0, 3) != 0,
                 longint'($urandom_range(0, 33554431)) - 16777216,
                 longint'($urandom_range(0, 262143)) - 131072,
                 $urandom_range(0, 1), $urandom_range(0, 5),
                 $urandom_range(0, 39) == 0);
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
